// File: rtl/demux_1ton_stream_pkg.sv
// Shared helpers for the 1-to-N stream demux: select-width sizing and the
// saturating increment used by the drop counter.
package demux_pkg;

  localparam int CNT_MAX_W = 32;

  // A 2-channel demux still needs a 1-bit select.
  function automatic int sel_w(input int ch);
    return (ch > 2) ? $clog2(ch) : 1;
  endfunction

  // Increments v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] v,
                                                   input int w);
    logic [CNT_MAX_W-1:0] top;
    top = (w >= CNT_MAX_W) ? '1 : ((CNT_MAX_W'(1) << w) - CNT_MAX_W'(1));
    return (v == top) ? v : v + CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/demux_1ton_stream_if.sv
// Producer-side and consumer-side handshakes of the 1-to-N demux.
// The slave modport is the demux; the master modport is its environment.
interface demux_1ton_stream_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CH    = 4,
  parameter int SEL_W = sel_w(CH),
  parameter int CNT_W = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [SEL_W-1:0]      in_sel;
  logic [CH-1:0]         out_valid;
  logic [CH-1:0]         out_ready;
  logic [CH*WIDTH-1:0]   out_data;
  logic                  err;
  logic [CNT_W-1:0]      drop_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, err, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, err, drop_cnt
  );

endinterface

// File: rtl/demux_1ton_stream_slot.sv
// One-entry holding register for a single output channel; data reads zero when empty.
// 1-cycle load latency; accepts a push in the same cycle as a pop, so it never throttles a ready consumer.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             rdy,
  input  logic [WIDTH-1:0] din,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  logic pop;

  assign pop = vld & rdy;

  // Push takes priority: a simultaneous pop just makes room for the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (push) begin
      vld <= 1'b1;
      dat <= din;
    end else if (pop) begin
      vld <= 1'b0;
      dat <= '0;
    end
  end

endmodule

// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N valid/ready demux with per-channel one-entry slots, illegal-select drop counting.
// 1-cycle latency; in_ready stalls only when the selected slot is full and its consumer is not ready.
module demux_1ton_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CH    = 4,
  parameter int SEL_W = sel_w(CH),
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_1ton_stream_if.slave   bus
);

  logic [CH-1:0]             sel_hit;
  logic [CH-1:0]             push;
  logic [CH-1:0]             slot_vld;
  logic [CH-1:0][WIDTH-1:0]  slot_dat;
  logic                      legal;
  logic                      blocked;
  logic                      xfer;
  logic                      drop;
  logic                      err_q;
  logic [CNT_W-1:0]          drop_cnt_q;

  // A select past CH-1 matches no channel, which is exactly the illegal case.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < CH; k++) begin
      sel_hit[k] = (bus.in_sel == SEL_W'(k));
    end
  end

  assign legal   = |sel_hit;
  assign blocked = |(sel_hit & slot_vld & ~bus.out_ready);

  assign bus.in_ready = !rst && !blocked;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign push         = {CH{xfer}} & sel_hit;
  assign drop         = xfer && !legal;

  for (genvar g = 0; g < CH; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .push (push[g]),
      .rdy  (bus.out_ready[g]),
      .din  (bus.in_data),
      .vld  (slot_vld[g]),
      .dat  (slot_dat[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      err_q      <= 1'b1;
      drop_cnt_q <= CNT_W'(sat_inc(CNT_MAX_W'(drop_cnt_q), CNT_W));
    end
  end

  assign bus.out_valid = slot_vld;
  assign bus.out_data  = slot_dat;
  assign bus.err       = err_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule
